// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for the multi-cycle RV32I core: round-robin between
// instruction fetch and data access, one fixed-latency access in flight at a time.
module mem_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_maskmode,
  input  logic                  d_sext,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_maskmode,
  output logic                  mem_sext,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t                state;
  state_t                state_next;
  logic                  last_grant_d;
  logic                  grant_d;
  logic [3:0]            counter;
  logic                  cmd_we;
  logic [DATA_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [1:0]            cmd_maskmode;
  logic                  cmd_sext;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    state_next = state;
    if_ready   = 1'b0;
    d_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || !last_grant_d)) begin
          d_ready    = 1'b1;
          state_next = ISSUE;
        end else if (if_req) begin
          if_ready   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (counter == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      grant_d      <= 1'b0;
      counter      <= 4'd0;
      cmd_we       <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      cmd_maskmode <= 2'b00;
      cmd_sext     <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
    end else begin
      state <= state_next;
      if (d_ready) begin
        grant_d      <= 1'b1;
        last_grant_d <= 1'b1;
        cmd_we       <= d_we;
        cmd_addr     <= d_addr;
        cmd_wdata    <= d_wdata;
        cmd_maskmode <= d_maskmode;
        cmd_sext     <= d_sext;
      end else if (if_ready) begin
        grant_d      <= 1'b0;
        last_grant_d <= 1'b0;
        cmd_we       <= 1'b0;
        cmd_addr     <= if_addr;
        cmd_wdata    <= '0;
        cmd_maskmode <= 2'b10;
        cmd_sext     <= 1'b0;
      end
      if (state == ISSUE) begin
        counter <= CNT_LOAD;
      end else if (state == WAIT && counter != 4'd0) begin
        counter <= counter - 4'd1;
      end
      // Stores report completion with zero data rather than whatever the bus carries.
      if (state == WAIT && counter == 4'd0) begin
        if (grant_d) begin
          d_rdata <= cmd_we ? '0 : mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign busy         = (state != IDLE);
  assign mem_en       = (state == ISSUE);
  assign mem_we       = busy & cmd_we;
  assign mem_addr     = busy ? cmd_addr : '0;
  assign mem_wdata    = busy ? cmd_wdata : '0;
  assign mem_maskmode = busy ? cmd_maskmode : 2'b00;
  assign mem_sext     = busy & cmd_sext;
  assign if_rvalid    = (state == RESP) && !grant_d;
  assign d_rvalid     = (state == RESP) && grant_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected commands and
// responses, monitors pop and compare whenever the DUT strobes mem_en or rvalid.
module tb_mem_port_arbiter;

  localparam int L = 2;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
    logic        sext;
    int          cyc;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_sext, d_ready, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_maskmode;
  logic        mem_en, mem_we, mem_sext, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_maskmode;

  logic        l1_if_ready, l1_if_rvalid, l1_d_req, l1_d_sext, l1_d_ready, l1_d_rvalid;
  logic [31:0] l1_if_rdata, l1_d_addr, l1_d_rdata;
  logic [1:0]  l1_d_maskmode;
  logic        l1_mem_en, l1_mem_we, l1_mem_sext, l1_busy;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic [1:0]  l1_mem_maskmode;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  resp_t if_q[$];
  resp_t d_q[$];
  cmd_t  cmd_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_maskmode(d_maskmode), .d_sext(d_sext), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_maskmode(mem_maskmode), .mem_sext(mem_sext), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_port_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(32'h0), .if_ready(l1_if_ready),
    .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
    .d_req(l1_d_req), .d_we(1'b0), .d_addr(l1_d_addr), .d_wdata(32'h0),
    .d_maskmode(l1_d_maskmode), .d_sext(l1_d_sext), .d_ready(l1_d_ready),
    .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_maskmode(l1_mem_maskmode), .mem_sext(l1_mem_sext),
    .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h00: return 32'h00500093;
      32'h04: return 32'h00A00113;
      32'h08: return 32'h002081B3;
      32'h10: return 32'h55AA55AA;
      32'h20: return 32'h12345678;
      32'h24: return 32'h9ABCDEF0;
      default: return 32'h0;
    endcase
  endfunction

  // Memory returns data exactly L cycles after mem_en; any other cycle carries junk.
  logic [31:0] pipe_data [16];
  logic [15:0] pipe_v = '0;
  always @(posedge clk) begin
    pipe_v       <= {pipe_v[14:0], mem_en};
    pipe_data[0] <= mem_model(mem_addr);
    for (int i = 1; i < 16; i++) pipe_data[i] <= pipe_data[i-1];
  end
  assign mem_rdata = pipe_v[L-1] ? pipe_data[L-1] : 32'hBAD0BAD0;

  always @(posedge clk) l1_mem_rdata <= l1_mem_en ? 32'hFFFFFF80 : 32'h0BAD0BAD;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    resp_t r;
    cmd_t  c;
    if (rst === 1'b0) begin
      if (if_rvalid) begin
        if (if_q.size() == 0) check_output("if_rvalid_unexpected", {31'b0, if_rvalid}, 32'h0);
        else begin
          r = if_q.pop_front();
          check_output("if_rdata", if_rdata, r.data);
          check_output("if_rvalid_cycle", cyc, r.cyc);
        end
      end
      if (d_rvalid) begin
        if (d_q.size() == 0) check_output("d_rvalid_unexpected", {31'b0, d_rvalid}, 32'h0);
        else begin
          r = d_q.pop_front();
          check_output("d_rdata", d_rdata, r.data);
          check_output("d_rvalid_cycle", cyc, r.cyc);
        end
      end
      if (mem_en) begin
        if (cmd_q.size() == 0) check_output("mem_en_unexpected", {31'b0, mem_en}, 32'h0);
        else begin
          c = cmd_q.pop_front();
          check_output("mem_en_cycle", cyc, c.cyc);
          check_output("mem_we", {31'b0, mem_we}, {31'b0, c.we});
          check_output("mem_addr", mem_addr, c.addr);
          check_output("mem_wdata", mem_wdata, c.wdata);
          check_output("mem_maskmode", {30'b0, mem_maskmode}, {30'b0, c.mask});
          check_output("mem_sext", {31'b0, mem_sext}, {31'b0, c.sext});
        end
      end
    end
  end

  task automatic push_expect(input bit is_d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] mask,
                             input logic sext, input logic [31:0] data, input int t);
    cmd_t  c;
    resp_t r;
    c.we    = we;
    c.addr  = addr;
    c.wdata = wdata;
    c.mask  = mask;
    c.sext  = sext;
    c.cyc   = t + 1;
    cmd_q.push_back(c);
    r.data = data;
    r.cyc  = t + 2 + L;
    if (is_d) d_q.push_back(r);
    else if_q.push_back(r);
  endtask

  task automatic apply_stimulus(input bit is_d, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] mask,
                                input logic sext, input logic [31:0] data,
                                input bit drop, output int t);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      d_maskmode = mask; d_sext = sext;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    t = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (is_d ? d_ready : if_ready) got = 1'b1;
    end
    if (!got) check_output("accept_timeout", 32'h0, 32'h1);
    else begin
      t = cyc;
      if (is_d) push_expect(1'b1, we, addr, wdata, mask, sext, data, t);
      else push_expect(1'b0, 1'b0, addr, 32'h0, 2'b10, 1'b0, data, t);
    end
    @(posedge clk); #1;
    if (drop) begin
      if (is_d) d_req = 1'b0;
      else if_req = 1'b0;
    end
  endtask

  initial begin
    int t0, t1, t2, tp;
    bit got, win_d;
    bit          seq_d    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] seq_addr [4] = '{32'h20, 32'h0, 32'h24, 32'h4};
    logic [31:0] seq_data [4] = '{32'h12345678, 32'h00500093, 32'h9ABCDEF0, 32'h00A00113};

    rst = 1'b1;
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_maskmode = 0; d_sext = 0;
    l1_d_req = 0; l1_d_addr = 0; l1_d_maskmode = 0; l1_d_sext = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_busy", {31'b0, busy}, 32'h0);
    check_output("reset_mem_en", {31'b0, mem_en}, 32'h0);
    check_output("reset_mem_addr", mem_addr, 32'h0);
    check_output("reset_if_rdata", if_rdata, 32'h0);
    check_output("reset_d_rdata", d_rdata, 32'h0);
    check_output("reset_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'h0);
    check_output("reset_ready", {30'b0, if_ready, d_ready}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] single fetch");
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h00500093, 1'b1, t0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_output("busy_window", {31'b0, busy}, (k <= 4) ? 32'h1 : 32'h0);
    end

    $display("[TB] store");
    apply_stimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b1, t0);
    repeat (6) @(posedge clk);

    $display("[TB] back-to-back fetches");
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h00500093, 1'b0, t0);
    apply_stimulus(1'b0, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 32'h00A00113, 1'b0, t1);
    apply_stimulus(1'b0, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 32'h002081B3, 1'b1, t2);
    check_output("fetch_interval_1", t1 - t0, 32'd5);
    check_output("fetch_interval_2", t2 - t1, 32'd5);
    repeat (6) @(posedge clk);

    $display("[TB] round robin");
    #1 rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = 32'h0; d_maskmode = 2'b10; d_sext = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    tp = -1;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (if_ready || d_ready) got = 1'b1;
      end
      if (!got) check_output("rr_timeout", 32'h0, 32'h1);
      else begin
        win_d = d_ready;
        check_output("rr_winner", {31'b0, win_d}, {31'b0, seq_d[n]});
        check_output("rr_loser_ready", {31'b0, win_d ? if_ready : d_ready}, 32'h0);
        if (tp >= 0) check_output("rr_interval", cyc - tp, 32'd5);
        tp = cyc;
        push_expect(win_d, 1'b0, seq_addr[n], 32'h0, 2'b10, 1'b0, seq_data[n], cyc);
        @(posedge clk); #1;
        if (win_d) d_addr = 32'h24;
        else if_addr = 32'h4;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (8) @(posedge clk);

    $display("[TB] reset during wait");
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_maskmode = 2'b10; d_sext = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (d_ready) got = 1'b1;
    end
    if (!got) check_output("abort_accept_timeout", 32'h0, 32'h1);
    t0 = cyc;
    begin
      cmd_t c;
      c.we = 1'b0; c.addr = 32'h20; c.wdata = 32'h0; c.mask = 2'b10; c.sext = 1'b0; c.cyc = t0 + 1;
      cmd_q.push_back(c);
    end
    @(posedge clk); #1 d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_output("abort_busy", {31'b0, busy}, 32'h0);
    check_output("abort_mem_en", {31'b0, mem_en}, 32'h0);
    check_output("abort_mem_addr", mem_addr, 32'h0);
    check_output("abort_mem_maskmode", {30'b0, mem_maskmode}, 32'h0);
    check_output("abort_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    check_output("abort_d_rdata", d_rdata, 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 32'h002081B3, 1'b1, t1);
    check_output("abort_next_accept", t1 - t0, 32'd4);
    repeat (8) @(posedge clk);

    $display("[TB] latency 1 sign-extended byte load");
    #1;
    l1_d_req = 1'b1; l1_d_addr = 32'h40; l1_d_maskmode = 2'b00; l1_d_sext = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (l1_d_ready) got = 1'b1;
    end
    if (!got) check_output("l1_accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1 l1_d_req = 1'b0;
    @(negedge clk);
    check_output("l1_mem_en", {31'b0, l1_mem_en}, 32'h1);
    check_output("l1_mem_sext", {31'b0, l1_mem_sext}, 32'h1);
    check_output("l1_mem_maskmode", {30'b0, l1_mem_maskmode}, 32'h0);
    check_output("l1_mem_addr", l1_mem_addr, 32'h40);
    @(negedge clk);
    check_output("l1_d_rvalid_early", {31'b0, l1_d_rvalid}, 32'h0);
    @(negedge clk);
    check_output("l1_d_rvalid", {31'b0, l1_d_rvalid}, 32'h1);
    check_output("l1_d_rdata", l1_d_rdata, 32'hFFFFFF80);

    repeat (4) @(posedge clk);
    check_output("if_queue_drained", if_q.size(), 32'h0);
    check_output("d_queue_drained", d_q.size(), 32'h0);
    check_output("cmd_queue_drained", cmd_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
